// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the instruction-fetch front end: default address and
// instruction widths, the sequential PC increment, and the {instr, pc} entry
// type stored by both the instruction queue and the in-flight pc FIFO.
package fetch_pkg;

    localparam int FETCH_ADDR_W  = 64;
    localparam int FETCH_INSTR_W = 32;

    // Distance between sequential instructions.
    localparam logic [FETCH_ADDR_W-1:0] PC_STEP = 64'd4;

    typedef struct packed {
        logic [FETCH_INSTR_W-1:0] instr;
        logic [FETCH_ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
// Circular buffer of DEPTH fetch_entry_t entries with flush.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   flush              empty the buffer (wins over push/pop)
//   push, push_data    write an entry at the tail (ignored when full)
//   pop                drop the head entry (ignored when empty)
//   head               entry at the read pointer
//   count, full, empty occupancy status
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Status flags and guarded push/pop; the head is read straight from the
    // storage so a new entry is visible the cycle after it is written.
    always_comb begin
        full    = (count == CNT_W'(DEPTH));
        empty   = (count == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        head    = mem[rd_ptr];
    end

    // Storage and pointers. Storage is cleared on reset so the head reads as
    // all zeros until the first write; a flush only rewinds the pointers.
    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue
// Instruction-fetch front end: generates sequential PCs, issues requests to a
// variable-latency in-order instruction memory, and buffers the returned
// instructions for decode. A redirect flushes everything and discards the
// responses still owed by the memory.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   imem_req/imem_addr/imem_gnt         request channel (accepted on req && gnt)
//   imem_rvalid/imem_rdata              in-order response channel
//   redirect/redirect_pc                flush and restart fetching at redirect_pc
//   dec_valid/dec_ready                 handshake towards decode
//   dec_instr/dec_pc/dec_pc_plus4       head instruction, its PC and PC+4
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter int                INSTR_W  = FETCH_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc,
    output logic [ADDR_W-1:0]  dec_pc_plus4
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] fetch_pc;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  drop;
    logic [CNT_W:0]    credits_used;

    logic              gnt_fire;
    logic              rsp_keep;
    logic              deq;

    fetch_entry_t      q_head;
    fetch_entry_t      q_wdata;
    logic [CNT_W-1:0]  q_count;
    logic              q_full;
    logic              q_empty;

    fetch_entry_t      pc_head;
    fetch_entry_t      pc_wdata;
    logic [CNT_W-1:0]  pc_count;
    logic              pc_full;
    logic              pc_empty;

    logic              unused_fifo_status;

    // Issue and handshake decisions. A request is only raised when every
    // outstanding response is guaranteed a queue slot, and never while stale
    // responses from before a redirect are still owed, so a late stale
    // response cannot be confused with a new one. The reset term keeps the
    // request low for as long as reset is held.
    always_comb begin
        credits_used = {1'b0, q_count} + {1'b0, inflight};
        imem_req     = rst_n && !redirect && (drop == '0)
                       && (credits_used < (CNT_W + 1)'(DEPTH));
        gnt_fire     = imem_req && imem_gnt;
        rsp_keep     = imem_rvalid && !redirect && (drop == '0);
        deq          = !q_empty && dec_ready && !redirect;
        q_wdata      = '{instr: imem_rdata, pc: pc_head.pc};
        pc_wdata     = '{instr: '0, pc: fetch_pc};
    end

    // Decode-side view of the queue head.
    always_comb begin
        imem_addr    = fetch_pc;
        dec_valid    = !q_empty;
        dec_instr    = q_head.instr;
        dec_pc       = q_head.pc;
        dec_pc_plus4 = q_head.pc + PC_STEP;
    end

    assign unused_fifo_status = ^{pc_head.instr, pc_count, pc_full, pc_empty, q_full};

    // Fetch PC: jumps on redirect, otherwise advances by one instruction on
    // every accepted request (wrapping at the top of the address space).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
        end else if (gnt_fire) begin
            fetch_pc <= fetch_pc + PC_STEP;
        end
    end

    // In-flight and drop accounting. On a redirect every response still owed
    // becomes stale: the current in-flight ones join the drop count, minus the
    // response arriving in that same cycle, which is discarded on the spot.
    // Otherwise responses are either discarded (while drop > 0) or retire an
    // in-flight request into the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
            drop     <= '0;
        end else if (redirect) begin
            drop     <= drop + inflight + CNT_W'(gnt_fire) - CNT_W'(imem_rvalid);
            inflight <= '0;
        end else begin
            inflight <= inflight + CNT_W'(gnt_fire) - CNT_W'(rsp_keep);
            if (imem_rvalid && (drop != '0)) begin
                drop <= drop - CNT_W'(1);
            end
        end
    end

    // Instruction queue feeding decode.
    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_instr_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .push      (rsp_keep),
        .push_data (q_wdata),
        .pop       (deq),
        .head      (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    // PCs of granted requests, in order, so each response can be tagged with
    // the address it was fetched from.
    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_pc_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .push      (gnt_fire),
        .push_data (pc_wdata),
        .pop       (rsp_keep),
        .head      (pc_head),
        .count     (pc_count),
        .full      (pc_full),
        .empty     (pc_empty)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
// Self-checking bench for fetch_queue. A behavioural model keeps the memory's
// outstanding requests (tagged stale after a redirect) and the list of
// delivered-but-not-consumed instructions, and predicts the request,
// address and decode outputs every cycle.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt    = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = '0;
    logic        redirect    = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        dec_valid;
    logic        dec_ready   = 1'b0;
    logic [31:0] dec_instr;
    logic [63:0] dec_pc;
    logic [63:0] dec_pc_plus4;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .ADDR_W   (64),
        .INSTR_W  (32),
        .RESET_PC (64'h0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_instr    (dec_instr),
        .dec_pc       (dec_pc),
        .dec_pc_plus4 (dec_pc_plus4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        logic [63:0] addr;
        bit          stale;
        int unsigned due;
    } req_t;

    ent_t        rq[$];
    req_t        pend[$];
    logic [63:0] issue_pc;
    int unsigned cyc;
    int          lat_min = 1;
    int          lat_max = 1;
    int          rsp_pct = 100;

    int checks = 0;
    int errors = 0;

    logic        exp_req, exp_valid, obs_req, obs_valid;
    logic [63:0] exp_addr, exp_pc, exp_plus4, obs_addr, obs_pc, obs_plus4;
    logic [31:0] exp_instr, obs_instr;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[33:2] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    task automatic modelReset();
        rq.delete();
        pend.delete();
        issue_pc = 64'h0;
        cyc      = 0;
    endtask

    task automatic neutralInputs();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        dec_ready   = 1'b0;
    endtask

    // Reset held for two edges, released just after a rising edge.
    task automatic doReset();
        rst_n = 1'b0;
        neutralInputs();
        modelReset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs on the falling edge, predict and sample
    // outputs, then advance the model at the rising edge.
    task automatic applyStimulus(input bit redir, input logic [63:0] rpc,
                                 input bit rdy, input bit gnt);
        bit          rsp, grant, pop;
        int          n_stale;
        int unsigned c;
        req_t        r;
        @(negedge clk);
        c   = cyc;
        rsp = (pend.size() > 0) && (pend[0].due <= c) && ($urandom_range(99) < rsp_pct);
        n_stale = 0;
        foreach (pend[i]) if (pend[i].stale) n_stale++;
        redirect    = redir;
        redirect_pc = rpc;
        dec_ready   = rdy;
        imem_gnt    = gnt;
        imem_rvalid = rsp;
        imem_rdata  = rsp ? instr_of(pend[0].addr) : $urandom;
        exp_valid = (rq.size() > 0);
        exp_pc    = exp_valid ? rq[0].pc : 64'h0;
        exp_instr = exp_valid ? rq[0].instr : 32'h0;
        exp_plus4 = exp_pc + 64'd4;
        exp_req   = !redir && (n_stale == 0) && ((rq.size() + pend.size()) < DEPTH);
        exp_addr  = issue_pc;
        #1;
        obs_req   = imem_req;
        obs_addr  = imem_addr;
        obs_valid = dec_valid;
        obs_pc    = dec_pc;
        obs_instr = dec_instr;
        obs_plus4 = dec_pc_plus4;
        grant = exp_req && gnt;
        pop   = exp_valid && rdy && !redir;
        @(posedge clk);
        cyc++;
        if (redir) begin
            rq.delete();
            if (rsp) void'(pend.pop_front());
            foreach (pend[i]) pend[i].stale = 1'b1;
            issue_pc = rpc;
        end else begin
            if (pop) void'(rq.pop_front());
            if (rsp) begin
                r = pend.pop_front();
                if (!r.stale) rq.push_back('{pc: r.addr, instr: instr_of(r.addr)});
            end
            if (grant) begin
                pend.push_back('{addr: issue_pc, stale: 1'b0,
                                 due: c + $urandom_range(lat_max, lat_min)});
                issue_pc = issue_pc + 64'd4;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        neutralInputs();
        modelReset();
        repeat (2) @(posedge clk);
        #2;
        checks += 6;
        if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %b want 0", imem_req); end
        if (imem_addr !== 64'h0) begin errors++; $display("[TB] FAIL reset_addr got %h want 0", imem_addr); end
        if (dec_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", dec_valid); end
        if (dec_instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr got %h want 0", dec_instr); end
        if (dec_pc !== 64'h0) begin errors++; $display("[TB] FAIL reset_pc got %h want 0", dec_pc); end
        if (dec_pc_plus4 !== 64'h4) begin errors++; $display("[TB] FAIL reset_plus4 got %h want 4", dec_pc_plus4); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL first_req got %b want 1", imem_req); end
    endtask

    task automatic test_stream();
        lat_min = 1; lat_max = 1; rsp_pct = 100;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 64'h0, 1'b1, 1'b1);
            checks += 3;
            if (obs_req !== exp_req) begin errors++; $display("[TB] FAIL stream_req cyc=%0d got %b want %b", i, obs_req, exp_req); end
            if (obs_addr !== exp_addr) begin errors++; $display("[TB] FAIL stream_addr cyc=%0d got %h want %h", i, obs_addr, exp_addr); end
            if (obs_valid !== exp_valid) begin errors++; $display("[TB] FAIL stream_valid cyc=%0d got %b want %b", i, obs_valid, exp_valid); end
            if (exp_valid) begin
                checks += 3;
                if (obs_pc !== exp_pc) begin errors++; $display("[TB] FAIL stream_pc cyc=%0d got %h want %h", i, obs_pc, exp_pc); end
                if (obs_instr !== exp_instr) begin errors++; $display("[TB] FAIL stream_instr cyc=%0d got %h want %h", i, obs_instr, exp_instr); end
                if (obs_plus4 !== exp_plus4) begin errors++; $display("[TB] FAIL stream_plus4 cyc=%0d got %h want %h", i, obs_plus4, exp_plus4); end
            end
        end
    endtask

    task automatic test_stall();
        bit rdy;
        doReset();
        lat_min = 1; lat_max = 1; rsp_pct = 100;
        for (int i = 0; i < 22; i++) begin
            rdy = (i >= 10);
            applyStimulus(1'b0, 64'h0, rdy, 1'b1);
            checks += 3;
            if (obs_req !== exp_req) begin errors++; $display("[TB] FAIL stall_req cyc=%0d got %b want %b", i, obs_req, exp_req); end
            if (obs_addr !== exp_addr) begin errors++; $display("[TB] FAIL stall_addr cyc=%0d got %h want %h", i, obs_addr, exp_addr); end
            if (obs_valid !== exp_valid) begin errors++; $display("[TB] FAIL stall_valid cyc=%0d got %b want %b", i, obs_valid, exp_valid); end
            if (exp_valid) begin
                checks += 2;
                if (obs_pc !== exp_pc) begin errors++; $display("[TB] FAIL stall_pc cyc=%0d got %h want %h", i, obs_pc, exp_pc); end
                if (obs_instr !== exp_instr) begin errors++; $display("[TB] FAIL stall_instr cyc=%0d got %h want %h", i, obs_instr, exp_instr); end
            end
            if (i == 9) begin
                checks += 2;
                if (obs_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_full_req got %b want 0", obs_req); end
                if (obs_addr !== 64'd16) begin errors++; $display("[TB] FAIL stall_next_addr got %h want 10", obs_addr); end
            end
            if (i == 10) begin
                checks++;
                if (obs_pc !== 64'h0) begin errors++; $display("[TB] FAIL stall_first_out got %h want 0", obs_pc); end
            end
        end
    endtask

    task automatic test_redirect_inflight();
        bit          seen;
        logic [63:0] first_pc;
        doReset();
        lat_min = 3; lat_max = 3; rsp_pct = 100;
        seen = 1'b0;
        first_pc = '0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(i == 2, 64'h100, 1'b1, 1'b1);
            checks += 3;
            if (obs_req !== exp_req) begin errors++; $display("[TB] FAIL redir_req cyc=%0d got %b want %b", i, obs_req, exp_req); end
            if (obs_addr !== exp_addr) begin errors++; $display("[TB] FAIL redir_addr cyc=%0d got %h want %h", i, obs_addr, exp_addr); end
            if (obs_valid !== exp_valid) begin errors++; $display("[TB] FAIL redir_valid cyc=%0d got %b want %b", i, obs_valid, exp_valid); end
            if (exp_valid) begin
                checks += 2;
                if (obs_pc !== exp_pc) begin errors++; $display("[TB] FAIL redir_pc cyc=%0d got %h want %h", i, obs_pc, exp_pc); end
                if (obs_instr !== exp_instr) begin errors++; $display("[TB] FAIL redir_instr cyc=%0d got %h want %h", i, obs_instr, exp_instr); end
            end
            if (obs_valid === 1'b1 && !seen) begin
                seen = 1'b1;
                first_pc = obs_pc;
            end
        end
        checks++;
        if (!seen || first_pc !== 64'h100) begin
            errors++; $display("[TB] FAIL redir_first_pc seen=%b got %h want 100", seen, first_pc);
        end
    endtask

    task automatic test_back_to_back();
        bit          seen;
        logic [63:0] first_pc, rpc;
        doReset();
        lat_min = 3; lat_max = 3; rsp_pct = 100;
        seen = 1'b0;
        first_pc = '0;
        for (int i = 0; i < 20; i++) begin
            rpc = (i == 3) ? 64'h200 : 64'h300;
            applyStimulus(i == 3 || i == 4, rpc, 1'b1, 1'b1);
            checks += 3;
            if (obs_req !== exp_req) begin errors++; $display("[TB] FAIL b2b_req cyc=%0d got %b want %b", i, obs_req, exp_req); end
            if (obs_addr !== exp_addr) begin errors++; $display("[TB] FAIL b2b_addr cyc=%0d got %h want %h", i, obs_addr, exp_addr); end
            if (obs_valid !== exp_valid) begin errors++; $display("[TB] FAIL b2b_valid cyc=%0d got %b want %b", i, obs_valid, exp_valid); end
            if (exp_valid) begin
                checks++;
                if (obs_pc !== exp_pc) begin errors++; $display("[TB] FAIL b2b_pc cyc=%0d got %h want %h", i, obs_pc, exp_pc); end
            end
            if (i > 4 && obs_valid === 1'b1 && !seen) begin
                seen = 1'b1;
                first_pc = obs_pc;
            end
        end
        checks++;
        if (!seen || first_pc !== 64'h300) begin
            errors++; $display("[TB] FAIL b2b_first_pc seen=%b got %h want 300", seen, first_pc);
        end
    endtask

    task automatic test_redirect_coincident();
        doReset();
        lat_min = 1; lat_max = 1; rsp_pct = 100;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(i == 6, 64'h400, 1'b1, 1'b1);
            checks += 3;
            if (obs_req !== exp_req) begin errors++; $display("[TB] FAIL coinc_req cyc=%0d got %b want %b", i, obs_req, exp_req); end
            if (obs_addr !== exp_addr) begin errors++; $display("[TB] FAIL coinc_addr cyc=%0d got %h want %h", i, obs_addr, exp_addr); end
            if (obs_valid !== exp_valid) begin errors++; $display("[TB] FAIL coinc_valid cyc=%0d got %b want %b", i, obs_valid, exp_valid); end
            if (exp_valid) begin
                checks++;
                if (obs_pc !== exp_pc) begin errors++; $display("[TB] FAIL coinc_pc cyc=%0d got %h want %h", i, obs_pc, exp_pc); end
            end
            if (i == 7) begin
                checks += 3;
                if (obs_valid !== 1'b0) begin errors++; $display("[TB] FAIL coinc_after_valid got %b want 0", obs_valid); end
                if (obs_req !== 1'b1) begin errors++; $display("[TB] FAIL coinc_after_req got %b want 1", obs_req); end
                if (obs_addr !== 64'h400) begin errors++; $display("[TB] FAIL coinc_after_addr got %h want 400", obs_addr); end
            end
        end
    endtask

    task automatic test_wrap();
        int          k;
        logic [63:0] pc0, pc1, p40;
        doReset();
        lat_min = 1; lat_max = 1; rsp_pct = 100;
        k = 0;
        pc0 = '0; pc1 = '1; p40 = '1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(i == 1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b1);
            checks += 2;
            if (obs_req !== exp_req) begin errors++; $display("[TB] FAIL wrap_req cyc=%0d got %b want %b", i, obs_req, exp_req); end
            if (obs_addr !== exp_addr) begin errors++; $display("[TB] FAIL wrap_addr cyc=%0d got %h want %h", i, obs_addr, exp_addr); end
            if (exp_valid) begin
                checks += 2;
                if (obs_pc !== exp_pc) begin errors++; $display("[TB] FAIL wrap_pc cyc=%0d got %h want %h", i, obs_pc, exp_pc); end
                if (obs_plus4 !== exp_plus4) begin errors++; $display("[TB] FAIL wrap_plus4 cyc=%0d got %h want %h", i, obs_plus4, exp_plus4); end
            end
            if (i > 1 && obs_valid === 1'b1) begin
                if (k == 0) begin pc0 = obs_pc; p40 = obs_plus4; end
                if (k == 1) pc1 = obs_pc;
                k++;
            end
        end
        checks += 3;
        if (pc0 !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_first_pc got %h want fffffffffffffffc", pc0); end
        if (p40 !== 64'h0) begin errors++; $display("[TB] FAIL wrap_first_plus4 got %h want 0", p40); end
        if (pc1 !== 64'h0) begin errors++; $display("[TB] FAIL wrap_second_pc got %h want 0", pc1); end
    endtask

    task automatic test_random();
        bit          redir;
        logic [63:0] rpc;
        doReset();
        lat_min = 1; lat_max = 4; rsp_pct = 70;
        for (int i = 0; i < 400; i++) begin
            redir = ($urandom_range(99) < 4);
            rpc   = ($urandom_range(1) == 1) ? 64'hFFFF_FFFF_FFFF_FFF0 : {32'h0, $urandom};
            rpc   = rpc & ~64'h3;
            applyStimulus(redir, rpc, $urandom_range(99) < 60, $urandom_range(99) < 75);
            checks += 3;
            if (obs_req !== exp_req) begin errors++; $display("[TB] FAIL rand_req cyc=%0d got %b want %b", i, obs_req, exp_req); end
            if (obs_addr !== exp_addr) begin errors++; $display("[TB] FAIL rand_addr cyc=%0d got %h want %h", i, obs_addr, exp_addr); end
            if (obs_valid !== exp_valid) begin errors++; $display("[TB] FAIL rand_valid cyc=%0d got %b want %b", i, obs_valid, exp_valid); end
            if (exp_valid) begin
                checks += 3;
                if (obs_pc !== exp_pc) begin errors++; $display("[TB] FAIL rand_pc cyc=%0d got %h want %h", i, obs_pc, exp_pc); end
                if (obs_instr !== exp_instr) begin errors++; $display("[TB] FAIL rand_instr cyc=%0d got %h want %h", i, obs_instr, exp_instr); end
                if (obs_plus4 !== exp_plus4) begin errors++; $display("[TB] FAIL rand_plus4 cyc=%0d got %h want %h", i, obs_plus4, exp_plus4); end
            end
        end
    endtask

    task automatic test_async_reset();
        doReset();
        lat_min = 2; lat_max = 2; rsp_pct = 100;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 64'h0, 1'b1, 1'b1);
        end
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks += 6;
        if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL areset_req got %b want 0", imem_req); end
        if (imem_addr !== 64'h0) begin errors++; $display("[TB] FAIL areset_addr got %h want 0", imem_addr); end
        if (dec_valid !== 1'b0) begin errors++; $display("[TB] FAIL areset_valid got %b want 0", dec_valid); end
        if (dec_instr !== 32'h0) begin errors++; $display("[TB] FAIL areset_instr got %h want 0", dec_instr); end
        if (dec_pc !== 64'h0) begin errors++; $display("[TB] FAIL areset_pc got %h want 0", dec_pc); end
        if (dec_pc_plus4 !== 64'h4) begin errors++; $display("[TB] FAIL areset_plus4 got %h want 4", dec_pc_plus4); end
        neutralInputs();
        modelReset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 64'h0, 1'b1, 1'b1);
            checks += 3;
            if (obs_req !== exp_req) begin errors++; $display("[TB] FAIL restart_req cyc=%0d got %b want %b", i, obs_req, exp_req); end
            if (obs_addr !== exp_addr) begin errors++; $display("[TB] FAIL restart_addr cyc=%0d got %h want %h", i, obs_addr, exp_addr); end
            if (obs_valid !== exp_valid) begin errors++; $display("[TB] FAIL restart_valid cyc=%0d got %b want %b", i, obs_valid, exp_valid); end
            if (exp_valid) begin
                checks++;
                if (obs_pc !== exp_pc) begin errors++; $display("[TB] FAIL restart_pc cyc=%0d got %h want %h", i, obs_pc, exp_pc); end
            end
            if (i == 0) begin
                checks += 2;
                if (obs_req !== 1'b1) begin errors++; $display("[TB] FAIL restart_first_req got %b want 1", obs_req); end
                if (obs_addr !== 64'h0) begin errors++; $display("[TB] FAIL restart_first_addr got %h want 0", obs_addr); end
            end
        end
    endtask

    initial begin
        test_reset();
        modelReset();
        test_stream();
        test_stall();
        test_redirect_inflight();
        test_back_to_back();
        test_redirect_coincident();
        test_wrap();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
